dram_read_responder: RTL and testbench

- On-chip responder for the engine's DRAM read-burst interface (rd_id / rd_addr / rd_len / rd_info handshake; 256-bit rd_data handshake).
- Serves burst requests from a preloadable block-RAM image of reference-sequence memory.
- Stands in for the AXI bus arbiter + DRAM in standalone engine builds and benches.
- Provides a request queue, a burst sequencer, and a backpressure-safe data return path.

---
 rtl/dram_read_responder.sv | 210 +++++++++++++++++++++
 tb/tb_dram_read_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_read_responder.sv
// dram_read_responder: on-chip stand-in for DRAM on the engine's read-burst
// interface. Requests are queued, a two-state sequencer walks each burst
// through a block-RAM image, and a 2-entry credit-managed output buffer
// returns beats in request order under arbitrary backpressure.
// Optional build macro: DRAM_READ_RESPONDER_RANGE_CHECK_EN (out-of-range
// bursts return zero data with rd_err_out=1 instead of wrapping).
module dram_read_responder #(
  parameter int ADDR_WIDTH     = 10,
  parameter int REQ_FIFO_DEPTH = 4,
  parameter int DATA_WIDTH     = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            rd_id_in,
  input  logic [31:0]           rd_addr_in,
  input  logic [7:0]            rd_len_in,
  input  logic                  rd_info_valid_in,
  output logic                  rd_info_rdy_out,
  output logic [DATA_WIDTH-1:0] rd_data_out,
  output logic [5:0]            rd_data_id_out,
  output logic                  rd_data_last_out,
  output logic                  rd_err_out,
  output logic                  rd_data_valid_out,
  input  logic                  rd_data_rdy_in,
  input  logic                  wr_en_in,
  input  logic [ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [DATA_WIDTH-1:0] wr_data_in
);

  localparam int PTR_W = $clog2(REQ_FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  // ---------------- request FIFO ----------------
  logic [5:0]            rq_id_q   [REQ_FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] rq_addr_q [REQ_FIFO_DEPTH];
  logic [7:0]            rq_len_q  [REQ_FIFO_DEPTH];
  logic                  rq_err_q  [REQ_FIFO_DEPTH];
  logic [PTR_W-1:0]      rq_wptr_q, rq_wptr_d, rq_rptr_q, rq_rptr_d;
  logic [PTR_W:0]        rq_count_q, rq_count_d;
  logic                  ready_q, ready_d;
  logic                  rq_full, rq_push, rq_pop;
  logic [ADDR_WIDTH-1:0] req_word;
  logic                  req_err;
  logic                  unused_addr_bits;

  assign req_word        = rd_addr_in[ADDR_WIDTH+4:5];
  assign rq_full         = (rq_count_q == (PTR_W+1)'(REQ_FIFO_DEPTH));
  assign rd_info_rdy_out = ready_q & ~rq_full;
  assign rq_push         = rd_info_valid_in & rd_info_rdy_out;

`ifdef DRAM_READ_RESPONDER_RANGE_CHECK_EN
  // Flag requests whose upper address bits are set or whose last word lies past the image.
  logic [ADDR_WIDTH+8:0] req_end;
  assign req_end          = (ADDR_WIDTH+9)'(req_word) + (ADDR_WIDTH+9)'(rd_len_in);
  assign req_err          = (|rd_addr_in[31:ADDR_WIDTH+5]) | (|req_end[ADDR_WIDTH+8:ADDR_WIDTH]);
  assign unused_addr_bits = ^rd_addr_in[4:0];
`else
  // Upper address bits are ignored; bursts simply wrap around the image.
  assign req_err          = 1'b0;
  assign unused_addr_bits = ^{rd_addr_in[31:ADDR_WIDTH+5], rd_addr_in[4:0]};
`endif

  // Request FIFO storage (no reset needed: occupancy is tracked by the count).
  always_ff @(posedge clk) begin
    if (rq_push) begin
      rq_id_q[rq_wptr_q]   <= rd_id_in;
      rq_addr_q[rq_wptr_q] <= req_word;
      rq_len_q[rq_wptr_q]  <= rd_len_in;
      rq_err_q[rq_wptr_q]  <= req_err;
    end
  end

  // ---------------- sequencer ----------------
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [7:0]            beats_left_q, beats_left_d;
  logic [5:0]            cur_id_q, cur_id_d;
  logic                  cur_err_q, cur_err_d;
  logic                  issue, credit_ok;

  // ---------------- read pipeline and output buffer ----------------
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] mem_rdata_q;
  logic                  rd_v_q, rd_v_d, rd_last_q, rd_last_d, rd_err_q, rd_err_d;
  logic [5:0]            rd_id_q, rd_id_d;
  logic [DATA_WIDTH-1:0] ob_data_q [2];
  logic [5:0]            ob_id_q   [2];
  logic                  ob_last_q [2];
  logic                  ob_err_q  [2];
  logic                  ob_wptr_q, ob_wptr_d, ob_rptr_q, ob_rptr_d;
  logic [1:0]            ob_count_q, ob_count_d;
  logic                  ob_valid, ob_push, ob_pop;
  logic [2:0]            ob_occ;

  assign ob_valid = (ob_count_q != 2'd0);
  assign ob_pop   = ob_valid & rd_data_rdy_in;
  assign ob_push  = rd_v_q;
  // Buffered entries plus the read in flight, minus the beat leaving now, must leave room.
  assign ob_occ    = 3'(ob_count_q) + 3'(rd_v_q) - 3'(ob_pop);
  assign credit_ok = (ob_occ < 3'd2);

  // Next-state logic for the sequencer, FIFO pointers and output buffer bookkeeping.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    cur_id_d     = cur_id_q;
    cur_err_d    = cur_err_q;
    rq_pop       = 1'b0;
    issue        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rq_count_q != '0) begin
          rq_pop       = 1'b1;
          cur_addr_d   = rq_addr_q[rq_rptr_q];
          beats_left_d = rq_len_q[rq_rptr_q];
          cur_id_d     = rq_id_q[rq_rptr_q];
          cur_err_d    = rq_err_q[rq_rptr_q];
          state_d      = S_BURST;
        end
      end
      S_BURST: begin
        if (credit_ok) begin
          issue        = 1'b1;
          cur_addr_d   = cur_addr_q + ADDR_WIDTH'(1);
          beats_left_d = beats_left_q - 8'd1;
          if (beats_left_q == 8'd0) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rq_wptr_d  = rq_wptr_q + PTR_W'(rq_push);
    rq_rptr_d  = rq_rptr_q + PTR_W'(rq_pop);
    rq_count_d = rq_count_q + (PTR_W+1)'(rq_push) - (PTR_W+1)'(rq_pop);
    ready_d    = 1'b1;

    rd_v_d    = issue;
    rd_id_d   = cur_id_q;
    rd_last_d = (beats_left_q == 8'd0);
    rd_err_d  = cur_err_q;

    ob_wptr_d  = ob_wptr_q ^ ob_push;
    ob_rptr_d  = ob_rptr_q ^ ob_pop;
    ob_count_d = ob_count_q + 2'(ob_push) - 2'(ob_pop);
  end

  // Control state registers; reset discards queued requests, the active burst and buffered beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      cur_id_q     <= '0;
      cur_err_q    <= 1'b0;
      rq_wptr_q    <= '0;
      rq_rptr_q    <= '0;
      rq_count_q   <= '0;
      ready_q      <= 1'b0;
      rd_v_q       <= 1'b0;
      rd_id_q      <= '0;
      rd_last_q    <= 1'b0;
      rd_err_q     <= 1'b0;
      ob_wptr_q    <= 1'b0;
      ob_rptr_q    <= 1'b0;
      ob_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      cur_id_q     <= cur_id_d;
      cur_err_q    <= cur_err_d;
      rq_wptr_q    <= rq_wptr_d;
      rq_rptr_q    <= rq_rptr_d;
      rq_count_q   <= rq_count_d;
      ready_q      <= ready_d;
      rd_v_q       <= rd_v_d;
      rd_id_q      <= rd_id_d;
      rd_last_q    <= rd_last_d;
      rd_err_q     <= rd_err_d;
      ob_wptr_q    <= ob_wptr_d;
      ob_rptr_q    <= ob_rptr_d;
      ob_count_q   <= ob_count_d;
    end
  end

  // Backing image: read-first, so a same-cycle write returns the old word. Flagged bursts skip the read.
  always_ff @(posedge clk) begin
    if (wr_en_in) mem[wr_addr_in] <= wr_data_in;
    if (issue && !cur_err_q) mem_rdata_q <= mem[cur_addr_q];
  end

  // Output buffer storage; flagged beats are forced to zero data.
  always_ff @(posedge clk) begin
    if (ob_push) begin
      ob_data_q[ob_wptr_q] <= rd_err_q ? '0 : mem_rdata_q;
      ob_id_q[ob_wptr_q]   <= rd_id_q;
      ob_last_q[ob_wptr_q] <= rd_last_q;
      ob_err_q[ob_wptr_q]  <= rd_err_q;
    end
  end

  assign rd_data_valid_out = ob_valid;
  assign rd_data_out       = ob_valid ? ob_data_q[ob_rptr_q] : '0;
  assign rd_data_id_out    = ob_valid ? ob_id_q[ob_rptr_q]   : 6'd0;
  assign rd_data_last_out  = ob_valid & ob_last_q[ob_rptr_q];
  assign rd_err_out        = ob_valid & ob_err_q[ob_rptr_q];

endmodule

// File: tb/tb_dram_read_responder.sv
// Testbench for dram_read_responder: directed steps with a scoreboard queue of expected beats.
module tb_dram_read_responder;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [5:0]    rd_id_in = '0;
  logic [31:0]   rd_addr_in = '0;
  logic [7:0]    rd_len_in = '0;
  logic          rd_info_valid_in = 1'b0;
  logic          rd_info_rdy_out;
  logic [255:0]  rd_data_out;
  logic [5:0]    rd_data_id_out;
  logic          rd_data_last_out;
  logic          rd_err_out;
  logic          rd_data_valid_out;
  logic          rd_data_rdy_in = 1'b1;
  logic          wr_en_in = 1'b0;
  logic [AW-1:0] wr_addr_in = '0;
  logic [255:0]  wr_data_in = '0;

  dram_read_responder #(.ADDR_WIDTH(AW), .REQ_FIFO_DEPTH(4), .DATA_WIDTH(256)) dut (
    .clk(clk), .rst(rst),
    .rd_id_in(rd_id_in), .rd_addr_in(rd_addr_in), .rd_len_in(rd_len_in),
    .rd_info_valid_in(rd_info_valid_in), .rd_info_rdy_out(rd_info_rdy_out),
    .rd_data_out(rd_data_out), .rd_data_id_out(rd_data_id_out),
    .rd_data_last_out(rd_data_last_out), .rd_err_out(rd_err_out),
    .rd_data_valid_out(rd_data_valid_out), .rd_data_rdy_in(rd_data_rdy_in),
    .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    logic [5:0]   id;
    logic         last;
    logic         err;
  } beat_t;

  beat_t        exp_q[$];
  logic [255:0] model [0:1023];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           hs_cnt = 0;
  int           hs_cyc[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pattern(input int k);
    return (256'(k) << 128) | 256'(k);
  endfunction

  // Monitor: score each handshake, and check that a stalled beat does not change.
  beat_t        e;
  logic         stalled = 1'b0;
  logic [255:0] held_data;
  logic [5:0]   held_id;
  logic         held_last, held_err;
  always @(negedge clk) begin
    if (rd_data_valid_out && !rd_data_rdy_in) begin
      if (stalled) begin
        chk("stall_data", rd_data_out, held_data);
        chk("stall_id", 256'(rd_data_id_out), 256'(held_id));
        chk("stall_last", 256'(rd_data_last_out), 256'(held_last));
        chk("stall_err", 256'(rd_err_out), 256'(held_err));
      end
      stalled   = 1'b1;
      held_data = rd_data_out;
      held_id   = rd_data_id_out;
      held_last = rd_data_last_out;
      held_err  = rd_err_out;
    end else begin
      stalled = 1'b0;
    end
    if (rd_data_valid_out && rd_data_rdy_in) begin
      hs_cnt++;
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 256'(rd_data_valid_out), 256'(0));
      end else begin
        e = exp_q.pop_front();
        $display("beat id=%0d last=%0b err=%0b data=%0h", rd_data_id_out, rd_data_last_out, rd_err_out, rd_data_out);
        chk("beat_data", rd_data_out, e.data);
        chk("beat_id", 256'(rd_data_id_out), 256'(e.id));
        chk("beat_last", 256'(rd_data_last_out), 256'(e.last));
        chk("beat_err", 256'(rd_err_out), 256'(e.err));
      end
    end
  end

  task automatic push_exp(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len);
    logic [AW-1:0] w;
    logic          flag;
    beat_t         x;
    w    = addr[AW+4:5];
    flag = 1'b0;
`ifdef DRAM_READ_RESPONDER_RANGE_CHECK_EN
    flag = (addr[31:AW+5] != 0) || ((int'(w) + int'(len)) > 1023);
`endif
    for (int b = 0; b <= int'(len); b++) begin
      x.data = flag ? 256'd0 : model[w];
      x.id   = id;
      x.last = (b == int'(len));
      x.err  = flag;
      exp_q.push_back(x);
      w = w + AW'(1);
    end
  endtask

  // Drive one request; returns #1 after the accepting edge.
  task automatic send_req(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n;
    logic got;
    n   = 0;
    got = 1'b0;
    push_exp(id, addr, len);
    rd_id_in         = id;
    rd_addr_in       = addr;
    rd_len_in        = len;
    rd_info_valid_in = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      got = rd_info_rdy_out;
      @(posedge clk);
      n++;
    end
    #1 rd_info_valid_in = 1'b0;
    $display("request id=%0d addr=%0h len=%0d accepted=%0b", id, addr, len, got);
    if (!got) chk("req_accept", 256'(got), 256'(1));
  endtask

  task automatic wait_drain(input string tag, input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(tag, 256'(exp_q.size()), 256'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int base;

    // Reset state
    #12;
    chk("rst_valid", 256'(rd_data_valid_out), 256'(0));
    chk("rst_rdy", 256'(rd_info_rdy_out), 256'(0));
    chk("rst_data", rd_data_out, 256'(0));
    chk("rst_id", 256'(rd_data_id_out), 256'(0));
    chk("rst_last", 256'(rd_data_last_out), 256'(0));
    chk("rst_err", 256'(rd_err_out), 256'(0));
    #10 rst = 1'b1;   // t=22, between edges
    #2 chk("rdy_before_edge", 256'(rd_info_rdy_out), 256'(0));
    @(posedge clk);
    #1 chk("rdy_after_edge", 256'(rd_info_rdy_out), 256'(1));

    // Preload
    for (int k = 0; k < 1024; k++) model[k] = 256'd0;
    for (int k = 0; k < 10; k++) begin
      int w;
      w = (k < 8) ? k : 1014 + k;
      model[w]   = pattern(w);
      wr_en_in   = 1'b1;
      wr_addr_in = AW'(w);
      wr_data_in = pattern(w);
      @(posedge clk);
      #1;
    end
    wr_en_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic burst, latency and throughput
    base = hs_cyc.size();
    send_req(6'd5, 32'h40, 8'd3);
    n = 0;
    while (!rd_data_valid_out && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("first_beat_latency", 256'(n), 256'(3));
    wait_drain("drain_basic", 50);
    chk("basic_beats", 256'(hs_cyc.size() - base), 256'(4));
    if (hs_cyc.size() - base == 4)
      for (int i = 0; i < 3; i++)
        chk("basic_consecutive", 256'(hs_cyc[base+i+1] - hs_cyc[base+i]), 256'(1));

    // Toggling backpressure
    base = hs_cnt;
    send_req(6'd5, 32'h40, 8'd3);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      rd_data_rdy_in = (n % 3 == 0);
      @(posedge clk);
      #1;
      n++;
    end
    rd_data_rdy_in = 1'b1;
    chk("toggle_drain", 256'(exp_q.size()), 256'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("toggle_handshakes", 256'(hs_cnt - base), 256'(4));

    // Fill the request FIFO behind a stalled burst
    rd_data_rdy_in = 1'b0;
    send_req(6'd1, 32'h0, 8'd7);
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      send_req(6'(10 + k), 32'(k * 32), 8'd1);
      chk("rdy_after_accept", 256'(rd_info_rdy_out), 256'(k < 3));
    end
    rd_id_in         = 6'd20;
    rd_addr_in       = 32'h0;
    rd_len_in        = 8'd0;
    rd_info_valid_in = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("fifth_not_accepted", 256'(rd_info_rdy_out), 256'(0));
      @(posedge clk);
    end
    #1 rd_info_valid_in = 1'b0;
    rd_data_rdy_in = 1'b1;
    wait_drain("drain_fifo_full", 100);

    // Burst across the top of the image
    send_req(6'd7, 32'h7FC0, 8'd3);
    wait_drain("drain_wrap", 50);

    // Write/read collision on word 3
    send_req(6'd9, 32'h60, 8'd0);
    @(posedge clk);
    #1;
    wr_en_in   = 1'b1;
    wr_addr_in = AW'(3);
    wr_data_in = 256'hAA;
    @(posedge clk);
    #1 wr_en_in = 1'b0;
    model[3] = 256'hAA;
    wait_drain("drain_collision_old", 50);
    send_req(6'd9, 32'h60, 8'd0);
    wait_drain("drain_collision_new", 50);

    // Reset in the middle of a burst
    base = hs_cnt;
    send_req(6'd3, 32'h0, 8'd7);
    n = 0;
    while (hs_cnt < base + 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #2 rst = 1'b0;
    #1;
    chk("midrst_valid", 256'(rd_data_valid_out), 256'(0));
    chk("midrst_data", rd_data_out, 256'(0));
    chk("midrst_last", 256'(rd_data_last_out), 256'(0));
    chk("midrst_beats_before", 256'(hs_cnt - base), 256'(2));
    exp_q.delete();
    @(posedge clk);
    #1 chk("midrst_rdy", 256'(rd_info_rdy_out), 256'(0));
    #2 rst = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_rdy", 256'(rd_info_rdy_out), 256'(1));
    repeat (6) begin
      @(posedge clk);
      #1 chk("no_residual_beat", 256'(rd_data_valid_out), 256'(0));
    end
    send_req(6'd4, 32'h20, 8'd2);
    wait_drain("drain_after_reset", 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
